// File: rtl/pps_dds_pkg.sv
// rtl/pps_dds_pkg.sv - shared types, defaults and helpers for PPS-disciplined DDS control
//
// Contents:
//   state_t        : discipline FSM state encoding
//   DEF_*          : default rate/bound/threshold constants
//   CALC_W         : working width for wide signed arithmetic helpers
//   nominal_delta  : builds the nominal one-second PPS delta (2^frac_width)
//   sat32          : saturates a wide signed value to the signed 32-bit range
package pps_dds_pkg;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        WAIT_PPS   = 2'd1,
        CHECK      = 2'd2,
        UPDATE     = 2'd3
    } state_t;

    localparam int          CALC_W           = 128;
    localparam logic [31:0] DEF_DDS_RATE     = 32'hd6bf94d6;
    localparam logic [31:0] DEF_DDS_MIN      = 32'hd0000000;
    localparam logic [31:0] DEF_DDS_MAX      = 32'hdfffffff;
    localparam logic [31:0] DEF_MAX_ERR      = 32'h01000000;
    localparam logic [31:0] DEF_LOCK_THRESH  = 32'h00001000;

    function automatic logic [CALC_W-1:0] nominal_delta(input int frac_width);
        return CALC_W'(1) << frac_width;
    endfunction

    function automatic logic [31:0] sat32(input logic signed [CALC_W-1:0] v);
        logic signed [CALC_W-1:0] lo;
        logic signed [CALC_W-1:0] hi;
        lo = {{(CALC_W-31){1'b1}}, 31'd0};
        hi = {{(CALC_W-31){1'b0}}, {31{1'b1}}};
        if (v < lo) begin
            return 32'h8000_0000;
        end else if (v > hi) begin
            return 32'h7fff_ffff;
        end else begin
            return v[31:0];
        end
    endfunction

endpackage

// File: rtl/dds_rate_clamp.sv
// rtl/dds_rate_clamp.sv - combinational signed subtract-and-saturate of the DDS rate
//
// Ports:
//   rate      : current DDS rate (unsigned, DDS_WIDTH)
//   term      : signed correction term (DDS_WIDTH+2, two's complement)
//   rate_next : rate - term clamped to [DDS_MIN, DDS_MAX]
module dds_rate_clamp
    import pps_dds_pkg::*;
#(
    parameter int                   DDS_WIDTH = 32,
    parameter logic [DDS_WIDTH-1:0] DDS_MIN   = DEF_DDS_MIN,
    parameter logic [DDS_WIDTH-1:0] DDS_MAX   = DEF_DDS_MAX
) (
    input  logic [DDS_WIDTH-1:0] rate,
    input  logic [DDS_WIDTH+1:0] term,
    output logic [DDS_WIDTH-1:0] rate_next
);

    // Three extra bits: one for the sign of the zero-extended rate, two to
    // cover the full +/-2^(DDS_WIDTH+1) span of the term without overflow.
    localparam int DW = DDS_WIDTH + 3;

    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] lo;
    logic signed [DW-1:0] hi;

    assign lo   = $signed({3'b000, DDS_MIN});
    assign hi   = $signed({3'b000, DDS_MAX});
    assign diff = $signed({3'b000, rate}) - DW'($signed(term));

    always_comb begin
        if (diff < lo) begin
            rate_next = DDS_MIN;
        end else if (diff > hi) begin
            rate_next = DDS_MAX;
        end else begin
            rate_next = diff[DDS_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pps_dds_discipline.sv
// rtl/pps_dds_discipline.sv - PPS-disciplined DDS rate controller
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   time_pps, pps_valid  : PPS timestamp and its single-cycle qualifier
//   correction_mode      : 1 = dds follows the disciplined rate, 0 = dds holds
//   corr_shift           : proportional gain as arithmetic right shift of err
//   dds_load, dds_load_value : manual rate load (highest priority after reset)
//   dds                  : DDS increment to the accumulator
//   err_out, err_valid   : saturated signed interval error and its update pulse
//   locked               : lock indicator
//   outlier_cnt          : saturating count of rejected PPS intervals
module pps_dds_discipline
    import pps_dds_pkg::*;
#(
    parameter int                   TIMESTAMP_WIDTH  = 64,
    parameter int                   FRAC_WIDTH       = 32,
    parameter int                   DDS_WIDTH        = 32,
    parameter logic [DDS_WIDTH-1:0] DDS_RATE_DEFAULT = DEF_DDS_RATE,
    parameter logic [DDS_WIDTH-1:0] DDS_MIN          = DEF_DDS_MIN,
    parameter logic [DDS_WIDTH-1:0] DDS_MAX          = DEF_DDS_MAX,
    parameter logic [31:0]          MAX_ERR          = DEF_MAX_ERR,
    parameter logic [31:0]          LOCK_THRESH      = DEF_LOCK_THRESH,
    parameter int                   LOCK_COUNT       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [TIMESTAMP_WIDTH-1:0] time_pps,
    input  logic                       pps_valid,
    input  logic                       correction_mode,
    input  logic [4:0]                 corr_shift,
    input  logic                       dds_load,
    input  logic [DDS_WIDTH-1:0]       dds_load_value,
    output logic [DDS_WIDTH-1:0]       dds,
    output logic [31:0]                err_out,
    output logic                       err_valid,
    output logic                       locked,
    output logic [7:0]                 outlier_cnt
);

    localparam int TW  = TIMESTAMP_WIDTH;
    localparam int LCW = $clog2(LOCK_COUNT + 1);
    localparam logic [TW-1:0] NOMINAL = TW'(nominal_delta(FRAC_WIDTH));

    state_t state;
    state_t state_next;

    logic capture_first;
    logic capture_delta;
    logic do_check;
    logic do_update;

    logic [TW-1:0]        prev_ts;
    logic [TW-1:0]        delta;
    logic signed [TW-1:0] err_now;
    logic [TW-1:0]        abs_now;
    logic                 outlier_now;

    logic signed [TW-1:0] err_reg;
    logic                 outlier_reg;
    logic                 lock_ok_reg;
    logic                 outlier_flag;
    logic [LCW-1:0]       lock_cnt;

    logic [DDS_WIDTH-1:0] dds_rate;
    logic [DDS_WIDTH+1:0] term;
    logic [DDS_WIDTH-1:0] rate_next;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_FIRST;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a manual load always forces re-acquisition
    always_comb begin
        state_next = state;
        if (dds_load) begin
            state_next = WAIT_FIRST;
        end else begin
            case (state)
                WAIT_FIRST: if (pps_valid) state_next = WAIT_PPS;
                WAIT_PPS:   if (pps_valid) state_next = CHECK;
                CHECK:      state_next = UPDATE;
                UPDATE:     state_next = (outlier_reg && outlier_flag) ? WAIT_FIRST : WAIT_PPS;
                default:    state_next = WAIT_FIRST;
            endcase
        end
    end

    // Per-state datapath enables
    always_comb begin
        capture_first = 1'b0;
        capture_delta = 1'b0;
        do_check      = 1'b0;
        do_update     = 1'b0;
        if (!dds_load) begin
            case (state)
                WAIT_FIRST: capture_first = pps_valid;
                WAIT_PPS:   capture_delta = pps_valid;
                CHECK:      do_check      = 1'b1;
                UPDATE:     do_update     = 1'b1;
                default:    ;
            endcase
        end
    end

    // Error against the nominal second; the magnitude of the most negative
    // value wraps, but that case always has delta's MSB set and is an outlier.
    assign err_now     = $signed(delta - NOMINAL);
    assign abs_now     = err_now[TW-1] ? $unsigned(-err_now) : $unsigned(err_now);
    assign outlier_now = (abs_now > TW'(MAX_ERR)) || delta[TW-1];

    assign term = (DDS_WIDTH + 2)'(err_reg >>> corr_shift);

    dds_rate_clamp #(
        .DDS_WIDTH (DDS_WIDTH),
        .DDS_MIN   (DDS_MIN),
        .DDS_MAX   (DDS_MAX)
    ) u_clamp (
        .rate      (dds_rate),
        .term      (term),
        .rate_next (rate_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ts      <= '0;
            delta        <= '0;
            err_reg      <= '0;
            outlier_reg  <= 1'b0;
            lock_ok_reg  <= 1'b0;
            outlier_flag <= 1'b0;
            lock_cnt     <= '0;
            dds_rate     <= DDS_RATE_DEFAULT;
            dds          <= DDS_RATE_DEFAULT;
            err_out      <= '0;
            err_valid    <= 1'b0;
            locked       <= 1'b0;
            outlier_cnt  <= '0;
        end else begin
            // err_out/err_valid are registered out of CHECK so they are
            // visible during the UPDATE cycle.
            err_valid <= do_check;

            if (capture_first) begin
                prev_ts <= time_pps;
            end
            if (capture_delta) begin
                delta   <= time_pps - prev_ts;
                prev_ts <= time_pps;
            end
            if (do_check) begin
                err_reg     <= err_now;
                outlier_reg <= outlier_now;
                lock_ok_reg <= (abs_now <= TW'(LOCK_THRESH));
                err_out     <= sat32(CALC_W'(err_now));
            end

            if (dds_load) begin
                dds_rate <= dds_load_value;
                locked   <= 1'b0;
                lock_cnt <= '0;
            end else if (do_update) begin
                if (outlier_reg) begin
                    if (outlier_cnt != 8'hff) begin
                        outlier_cnt <= outlier_cnt + 8'd1;
                    end
                    locked       <= 1'b0;
                    lock_cnt     <= '0;
                    // Second outlier in a row clears the flag as the FSM re-acquires.
                    outlier_flag <= !outlier_flag;
                end else begin
                    dds_rate     <= rate_next;
                    outlier_flag <= 1'b0;
                    if (lock_ok_reg) begin
                        if (lock_cnt != LCW'(LOCK_COUNT)) begin
                            lock_cnt <= lock_cnt + LCW'(1);
                        end
                        if (lock_cnt >= LCW'(LOCK_COUNT - 1)) begin
                            locked <= 1'b1;
                        end
                    end else begin
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                    end
                end
            end

            if (correction_mode) begin
                dds <= dds_rate;
            end
        end
    end

endmodule

// File: tb/tb_pps_dds_discipline.sv
// tb/tb_pps_dds_discipline.sv - directed self-checking bench for pps_dds_discipline
module tb_pps_dds_discipline;

    logic        clk;
    logic        reset;
    logic [63:0] time_pps;
    logic        pps_valid;
    logic        correction_mode;
    logic [4:0]  corr_shift;
    logic        dds_load;
    logic [31:0] dds_load_value;
    logic [31:0] dds;
    logic [31:0] err_out;
    logic        err_valid;
    logic        locked;
    logic [7:0]  outlier_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] RATE_DEF = 32'hd6bf94d6;

    pps_dds_discipline dut (
        .clk             (clk),
        .reset           (reset),
        .time_pps        (time_pps),
        .pps_valid       (pps_valid),
        .correction_mode (correction_mode),
        .corr_shift      (corr_shift),
        .dds_load        (dds_load),
        .dds_load_value  (dds_load_value),
        .dds             (dds),
        .err_out         (err_out),
        .err_valid       (err_valid),
        .locked          (locked),
        .outlier_cnt     (outlier_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller one cycle after the PPS cycle (state CHECK when accepted as a delta)
    task automatic pps(input logic [63:0] ts);
        time_pps  = ts;
        pps_valid = 1'b1;
        tick();
        pps_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (dds !== RATE_DEF) $display("FAIL reset_dds: got %h want %h", dds, RATE_DEF); else n_pass++;
        n_checks++; if (err_out !== 32'h0) $display("FAIL reset_err_out: got %h want 0", err_out); else n_pass++;
        n_checks++; if (err_valid !== 1'b0) $display("FAIL reset_err_valid: got %b want 0", err_valid); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
        n_checks++; if (outlier_cnt !== 8'h0) $display("FAIL reset_outlier_cnt: got %h want 0", outlier_cnt); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_fast();
        corr_shift      = 5'd10;
        correction_mode = 1'b1;
        pps(64'h5_0000_0000);
        tick();
        tick();
        pps(64'h6_0000_0400);
        n_checks++; if (err_valid !== 1'b0) $display("FAIL fast_valid_n1: got %b want 0", err_valid); else n_pass++;
        tick();
        n_checks++; if (err_valid !== 1'b1) $display("FAIL fast_valid_n2: got %b want 1", err_valid); else n_pass++;
        n_checks++; if (err_out !== 32'h400) $display("FAIL fast_err: got %h want 00000400", err_out); else n_pass++;
        tick();
        n_checks++; if (err_valid !== 1'b0) $display("FAIL fast_valid_n3: got %b want 0", err_valid); else n_pass++;
        n_checks++; if (dut.dds_rate !== 32'hd6bf94d5) $display("FAIL fast_rate_n3: got %h want d6bf94d5", dut.dds_rate); else n_pass++;
        n_checks++; if (dds !== RATE_DEF) $display("FAIL fast_dds_n3: got %h want %h", dds, RATE_DEF); else n_pass++;
        tick();
        n_checks++; if (dds !== 32'hd6bf94d5) $display("FAIL fast_dds_n4: got %h want d6bf94d5", dds); else n_pass++;
    endtask

    task automatic test_slow();
        apply_reset();
        corr_shift      = 5'd10;
        correction_mode = 1'b1;
        pps(64'h5_0000_0000);
        pps(64'h5_FFFF_F800);
        tick();
        n_checks++; if (err_out !== 32'hFFFFF800) $display("FAIL slow_err: got %h want fffff800", err_out); else n_pass++;
        tick();
        tick();
        n_checks++; if (dds !== 32'hd6bf94d8) $display("FAIL slow_dds: got %h want d6bf94d8", dds); else n_pass++;

        apply_reset();
        correction_mode = 1'b0;
        pps(64'h5_0000_0000);
        pps(64'h5_FFFF_F800);
        tick();
        tick();
        tick();
        tick();
        n_checks++; if (dds !== RATE_DEF) $display("FAIL hold_dds: got %h want %h", dds, RATE_DEF); else n_pass++;
        n_checks++; if (dut.dds_rate !== 32'hd6bf94d8) $display("FAIL hold_rate: got %h want d6bf94d8", dut.dds_rate); else n_pass++;
        correction_mode = 1'b1;
        tick();
        tick();
        n_checks++; if (dds !== 32'hd6bf94d8) $display("FAIL resume_dds: got %h want d6bf94d8", dds); else n_pass++;
    endtask

    task automatic test_outlier();
        apply_reset();
        corr_shift = 5'd10;
        pps(64'h10_0000_0000);
        pps(64'h11_0000_0000);
        tick(); tick(); tick(); tick();
        n_checks++; if (outlier_cnt !== 8'd0) $display("FAIL outl_cnt0: got %0d want 0", outlier_cnt); else n_pass++;
        pps(64'h13_0000_0000);
        tick();
        n_checks++; if (err_valid !== 1'b1) $display("FAIL outl_valid: got %b want 1", err_valid); else n_pass++;
        n_checks++; if (err_out !== 32'h7fffffff) $display("FAIL outl_err_sat: got %h want 7fffffff", err_out); else n_pass++;
        tick();
        n_checks++; if (outlier_cnt !== 8'd1) $display("FAIL outl_cnt1: got %0d want 1", outlier_cnt); else n_pass++;
        tick();
        n_checks++; if (dds !== RATE_DEF) $display("FAIL outl_dds: got %h want %h", dds, RATE_DEF); else n_pass++;
        pps(64'h15_0000_0000);
        tick();
        tick();
        n_checks++; if (outlier_cnt !== 8'd2) $display("FAIL outl_cnt2: got %0d want 2", outlier_cnt); else n_pass++;
        tick();
        pps(64'h16_0000_0000);
        tick();
        n_checks++; if (err_valid !== 1'b0) $display("FAIL reacq_first: got %b want 0", err_valid); else n_pass++;
        tick();
        pps(64'h17_0000_0000);
        tick();
        n_checks++; if (err_valid !== 1'b1) $display("FAIL reacq_valid: got %b want 1", err_valid); else n_pass++;
        n_checks++; if (err_out !== 32'h0) $display("FAIL reacq_err: got %h want 0", err_out); else n_pass++;
        tick(); tick(); tick();
    endtask

    task automatic test_lock();
        logic [63:0] ts;
        apply_reset();
        corr_shift = 5'd10;
        ts = 64'h20_0000_0000;
        pps(ts);
        for (int i = 1; i <= 4; i++) begin
            ts = ts + 64'h1_0000_0100;
            pps(ts);
            if (i == 2) begin
                // A PPS arriving during CHECK must not disturb prev
                time_pps  = 64'h0;
                pps_valid = 1'b1;
                tick();
                pps_valid = 1'b0;
            end else begin
                tick();
            end
            n_checks++; if (err_out !== 32'h100) $display("FAIL lock_err_%0d: got %h want 00000100", i, err_out); else n_pass++;
            tick();
            n_checks++; if (locked !== (i == 4)) $display("FAIL lock_state_%0d: got %b want %b", i, locked, (i == 4)); else n_pass++;
            tick();
        end
        ts = ts + 64'h1_0000_2000;
        pps(ts);
        tick();
        n_checks++; if (err_out !== 32'h2000) $display("FAIL unlock_err: got %h want 00002000", err_out); else n_pass++;
        tick();
        n_checks++; if (locked !== 1'b0) $display("FAIL unlock: got %b want 0", locked); else n_pass++;
        tick();
        n_checks++; if (dds !== 32'hd6bf94ce) $display("FAIL unlock_dds: got %h want d6bf94ce", dds); else n_pass++;
    endtask

    task automatic test_saturation();
        corr_shift     = 5'd0;
        dds_load_value = 32'hdffffff0;
        dds_load       = 1'b1;
        tick();
        dds_load = 1'b0;
        n_checks++; if (dut.dds_rate !== 32'hdffffff0) $display("FAIL load_rate: got %h want dffffff0", dut.dds_rate); else n_pass++;
        pps(64'h30_0000_0000);
        pps(64'h30_FFF0_0000);
        tick();
        n_checks++; if (err_out !== 32'hFFF00000) $display("FAIL sat_hi_err: got %h want fff00000", err_out); else n_pass++;
        tick();
        n_checks++; if (dut.dds_rate !== 32'hdfffffff) $display("FAIL sat_hi_rate: got %h want dfffffff", dut.dds_rate); else n_pass++;
        tick();
        n_checks++; if (dds !== 32'hdfffffff) $display("FAIL sat_hi_dds: got %h want dfffffff", dds); else n_pass++;

        dds_load_value = 32'hd0000010;
        dds_load       = 1'b1;
        tick();
        dds_load = 1'b0;
        pps(64'h40_0000_0000);
        pps(64'h41_0000_0100);
        tick();
        tick();
        n_checks++; if (dut.dds_rate !== 32'hd0000000) $display("FAIL sat_lo_rate: got %h want d0000000", dut.dds_rate); else n_pass++;
    endtask

    task automatic test_load_pps();
        dds_load_value = RATE_DEF;
        dds_load       = 1'b1;
        time_pps       = 64'h42_0000_0100;
        pps_valid      = 1'b1;
        tick();
        dds_load  = 1'b0;
        pps_valid = 1'b0;
        tick();
        n_checks++; if (err_valid !== 1'b0) $display("FAIL loadpps_ignored: got %b want 0", err_valid); else n_pass++;
        n_checks++; if (dut.dds_rate !== RATE_DEF) $display("FAIL loadpps_rate: got %h want %h", dut.dds_rate, RATE_DEF); else n_pass++;
        pps(64'h43_0000_0000);
        tick();
        n_checks++; if (err_valid !== 1'b0) $display("FAIL loadpps_first: got %b want 0", err_valid); else n_pass++;
        pps(64'h44_0000_0000);
        tick();
        n_checks++; if (err_valid !== 1'b1) $display("FAIL loadpps_second: got %b want 1", err_valid); else n_pass++;
        tick(); tick();
    endtask

    task automatic test_reset_update();
        corr_shift      = 5'd10;
        correction_mode = 1'b1;
        dds_load_value  = 32'hd8000000;
        dds_load        = 1'b1;
        tick();
        dds_load = 1'b0;
        pps(64'h50_0000_0000);
        pps(64'h52_0000_0000);
        tick(); tick(); tick();
        n_checks++; if (dds !== 32'hd8000000) $display("FAIL pre_rst_dds: got %h want d8000000", dds); else n_pass++;
        pps(64'h53_0000_0400);
        tick();
        n_checks++; if (err_out !== 32'h400) $display("FAIL pre_rst_err: got %h want 00000400", err_out); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (dds !== RATE_DEF) $display("FAIL rst_upd_dds: got %h want %h", dds, RATE_DEF); else n_pass++;
        n_checks++; if (err_out !== 32'h0) $display("FAIL rst_upd_err: got %h want 0", err_out); else n_pass++;
        n_checks++; if (err_valid !== 1'b0) $display("FAIL rst_upd_valid: got %b want 0", err_valid); else n_pass++;
        n_checks++; if (outlier_cnt !== 8'd0) $display("FAIL rst_upd_outl: got %0d want 0", outlier_cnt); else n_pass++;
        n_checks++; if (dut.dds_rate !== RATE_DEF) $display("FAIL rst_upd_rate: got %h want %h", dut.dds_rate, RATE_DEF); else n_pass++;

        pps(64'hFFFF_FFFF_8000_0000);
        pps(64'h0000_0000_8000_0000);
        tick();
        n_checks++; if (err_valid !== 1'b1) $display("FAIL wrap_valid: got %b want 1", err_valid); else n_pass++;
        n_checks++; if (err_out !== 32'h0) $display("FAIL wrap_err: got %h want 0", err_out); else n_pass++;
        tick(); tick();
        n_checks++; if (dds !== RATE_DEF) $display("FAIL wrap_dds: got %h want %h", dds, RATE_DEF); else n_pass++;
    endtask

    initial begin
        reset           = 1'b1;
        time_pps        = '0;
        pps_valid       = 1'b0;
        correction_mode = 1'b1;
        corr_shift      = 5'd10;
        dds_load        = 1'b0;
        dds_load_value  = '0;

        test_reset();
        test_fast();
        test_slow();
        test_outlier();
        test_lock();
        test_saturation();
        test_load_pps();
        test_reset_update();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
